// File: rtl/friscv_h.sv
//==============================================================================
// Module      : friscv_h (package)
// Description : Shared definitions for the UART console master: UART register
//               map, status bit positions and console FSM state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package friscv_h;

    // UART register map (byte addresses)
    localparam logic [7:0] UART_CTRL   = 8'h00;
    localparam logic [7:0] UART_DIV    = 8'h04;
    localparam logic [7:0] UART_TX     = 8'h08;
    localparam logic [7:0] UART_RX     = 8'h0C;

    // Status register bit positions
    localparam int         TXFULL_BIT  = 10;
    localparam int         RXEMPTY_BIT = 11;

    // Console FSM state encoding
    typedef logic [2:0] console_state_t;
    localparam console_state_t ST_CFG_DIV  = 3'd0;
    localparam console_state_t ST_CFG_CTRL = 3'd1;
    localparam console_state_t ST_STATUS   = 3'd2;
    localparam console_state_t ST_DECIDE   = 3'd3;
    localparam console_state_t ST_TX_WR    = 3'd4;
    localparam console_state_t ST_RX_RD    = 3'd5;
    localparam console_state_t ST_WAIT     = 3'd6;

endpackage

`default_nettype wire

// File: rtl/friscv_uart_console_rxbuf.sv
//==============================================================================
// Module      : friscv_uart_console_rxbuf
// Description : One-entry RX byte holding register with valid/ready handshake.
//               Loaded by the console FSM after an RX-FIFO read; cleared when
//               the downstream consumer accepts the byte.
// Ports       : aclk/aresetn/srst - clock, async and sync resets
//               i_load/i_data     - load strobe and byte from the UART
//               i_ready           - downstream accept
//               o_valid/o_data    - held byte
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module friscv_uart_console_rxbuf (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       srst,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [7:0] o_data
);

    logic       r_valid;
    logic [7:0] r_data;

    // The FSM never loads while a byte is held, so load and accept never collide.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
        end else if (srst) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/friscv_uart_console.sv
//==============================================================================
// Module      : friscv_uart_console
// Description : Bus master in front of the UART register slave. Configures the
//               UART once after reset, then polls status and moves bytes
//               between the TX input stream and the TX FIFO, and between the
//               RX FIFO and the RX output stream, without ever stalling the
//               bus on a full or empty FIFO.
// Ports       : aclk, aresetn (async, active-low), srst (sync, active-high)
//               slv_*  - register bus master (en/wr/addr/wdata/strb, rdata/ready)
//               s_*    - TX byte stream in;  m_* - RX byte stream out
//               cfg_done - UART configured
// Options     : FRISCV_UART_CONSOLE_CRLF_EN - expand LF into CR,LF on TX
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module friscv_uart_console
    import friscv_h::*;
#(
    parameter int         ADDRW       = 16,
    parameter int         XLEN        = 32,
    parameter int         CLK_DIVIDER = 4,
    parameter logic [7:0] CTRL_INIT   = 8'h01,
    parameter int         POLL_GAP    = 0
)(
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    output logic              slv_en,
    output logic              slv_wr,
    output logic [ADDRW-1:0]  slv_addr,
    output logic [XLEN-1:0]   slv_wdata,
    output logic [XLEN/8-1:0] slv_strb,
    input  logic [XLEN-1:0]   slv_rdata,
    input  logic              slv_ready,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [7:0]        m_data,
    input  logic              m_ready,
    output logic              cfg_done
);

    localparam int              STRBW       = XLEN / 8;
    localparam logic [XLEN-1:0] c_div_wdata = XLEN'(CLK_DIVIDER[15:0]);
    localparam logic [15:0]     c_poll_gap  = POLL_GAP[15:0];

    console_state_t    r_state;
    logic              r_en;
    logic              r_wr;
    logic [ADDRW-1:0]  r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [STRBW-1:0]  r_strb;
    logic              r_s_ready;
    logic              r_cfg_done;
    logic              r_tx_full;
    logic              r_rx_empty;
    logic              r_rr;        // 0: TX served last, 1: RX served last
    logic [15:0]       r_gap;

    logic              w_m_valid;
    logic              w_rx_ok;
    logic              w_tx_ok;
    logic              w_rx_load;
    logic              w_send_cr;
    logic [7:0]        w_tx_byte;
    logic              w_unused_rdata;

`ifdef FRISCV_UART_CONSOLE_CRLF_EN
    logic              r_cr_sent;
    // An LF is preceded by a CR; s_data is held until s_ready so the
    // decision is the same on issue and on completion.
    assign w_send_cr = (s_data == 8'h0A) && !r_cr_sent;
    assign w_tx_byte = w_send_cr ? 8'h0D : s_data;
`else
    assign w_send_cr = 1'b0;
    assign w_tx_byte = s_data;
`endif

    // Only one RX byte is buffered, so reads wait until it is consumed.
    assign w_rx_ok   = !r_rx_empty && !w_m_valid;
    assign w_tx_ok   = s_valid && !r_tx_full;
    assign w_rx_load = (r_state == ST_RX_RD) && r_en && slv_ready;

    // Only the byte lanes and status bits are consumed from read data.
    assign w_unused_rdata = ^{slv_rdata, w_send_cr};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= ST_CFG_DIV;
            r_en       <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_s_ready  <= 1'b0;
            r_cfg_done <= 1'b0;
            r_tx_full  <= 1'b0;
            r_rx_empty <= 1'b1;
            r_rr       <= 1'b0;
            r_gap      <= '0;
`ifdef FRISCV_UART_CONSOLE_CRLF_EN
            r_cr_sent  <= 1'b0;
`endif
        end else if (srst) begin
            r_state    <= ST_CFG_DIV;
            r_en       <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_s_ready  <= 1'b0;
            r_cfg_done <= 1'b0;
            r_tx_full  <= 1'b0;
            r_rx_empty <= 1'b1;
            r_rr       <= 1'b0;
            r_gap      <= '0;
`ifdef FRISCV_UART_CONSOLE_CRLF_EN
            r_cr_sent  <= 1'b0;
`endif
        end else begin
            r_s_ready <= 1'b0;
            // Each bus state issues its request when slv_en is low and
            // retires it on slv_ready. Entering the next state with slv_en
            // low guarantees an idle cycle between requests.
            case (r_state)
                ST_CFG_DIV: begin
                    if (!r_en) begin
                        r_en    <= 1'b1;
                        r_wr    <= 1'b1;
                        r_addr  <= ADDRW'(UART_DIV);
                        r_wdata <= c_div_wdata;
                        r_strb  <= STRBW'(2'b11);
                    end else if (slv_ready) begin
                        r_en    <= 1'b0;
                        r_state <= ST_CFG_CTRL;
                    end
                end
                ST_CFG_CTRL: begin
                    if (!r_en) begin
                        r_en    <= 1'b1;
                        r_wr    <= 1'b1;
                        r_addr  <= ADDRW'(UART_CTRL);
                        r_wdata <= XLEN'(CTRL_INIT);
                        r_strb  <= STRBW'(1'b1);
                    end else if (slv_ready) begin
                        r_en       <= 1'b0;
                        r_cfg_done <= 1'b1;
                        r_state    <= ST_STATUS;
                    end
                end
                ST_STATUS: begin
                    if (!r_en) begin
                        r_en    <= 1'b1;
                        r_wr    <= 1'b0;
                        r_addr  <= ADDRW'(UART_CTRL);
                        r_wdata <= '0;
                        r_strb  <= '0;
                    end else if (slv_ready) begin
                        r_en       <= 1'b0;
                        r_tx_full  <= slv_rdata[TXFULL_BIT];
                        r_rx_empty <= slv_rdata[RXEMPTY_BIT];
                        r_state    <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    if (w_rx_ok && w_tx_ok) begin
                        r_state <= r_rr ? ST_TX_WR : ST_RX_RD;
                        r_rr    <= !r_rr;
                    end else if (w_rx_ok) begin
                        r_state <= ST_RX_RD;
                    end else if (w_tx_ok) begin
                        r_state <= ST_TX_WR;
                    end else begin
                        r_gap   <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_TX_WR: begin
                    if (!r_en) begin
                        r_en    <= 1'b1;
                        r_wr    <= 1'b1;
                        r_addr  <= ADDRW'(UART_TX);
                        r_wdata <= XLEN'(w_tx_byte);
                        r_strb  <= STRBW'(1'b1);
                    end else if (slv_ready) begin
                        r_en    <= 1'b0;
                        r_state <= ST_STATUS;
`ifdef FRISCV_UART_CONSOLE_CRLF_EN
                        if (w_send_cr) begin
                            r_cr_sent <= 1'b1;
                        end else begin
                            r_cr_sent <= 1'b0;
                            r_s_ready <= 1'b1;
                        end
`else
                        r_s_ready <= 1'b1;
`endif
                    end
                end
                ST_RX_RD: begin
                    if (!r_en) begin
                        r_en    <= 1'b1;
                        r_wr    <= 1'b0;
                        r_addr  <= ADDRW'(UART_RX);
                        r_wdata <= '0;
                        r_strb  <= '0;
                    end else if (slv_ready) begin
                        r_en    <= 1'b0;
                        r_state <= ST_STATUS;
                    end
                end
                ST_WAIT: begin
                    if (r_gap == c_poll_gap) begin
                        r_gap   <= '0;
                        r_state <= ST_STATUS;
                    end else begin
                        r_gap   <= r_gap + 16'd1;
                    end
                end
                default: begin
                    r_en    <= 1'b0;
                    r_state <= ST_CFG_DIV;
                end
            endcase
        end
    end

    friscv_uart_console_rxbuf u_rxbuf (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .i_load  (w_rx_load),
        .i_data  (slv_rdata[7:0]),
        .i_ready (m_ready),
        .o_valid (w_m_valid),
        .o_data  (m_data)
    );

    assign slv_en    = r_en;
    assign slv_wr    = r_wr;
    assign slv_addr  = r_addr;
    assign slv_wdata = r_wdata;
    assign slv_strb  = r_strb;
    assign s_ready   = r_s_ready;
    assign m_valid   = w_m_valid;
    assign cfg_done  = r_cfg_done;

endmodule

`default_nettype wire

// File: doc/friscv_uart_console.md
Name: friscv_uart_console

Overview:
- APB-style master sitting directly upstream of the UART register slave; converts two byte streams (CPU/debug TX in, RX out) into UART register accesses.
- After reset, programs the UART clock divider and control register once, then polls status (reg 0x0) and issues non-blocking TX-FIFO writes (0x8) and RX-FIFO reads (0xC).
- Checks the TX-full and RX-empty status bits before each access, so it never blocks the shared bus on a full or empty FIFO.

Parameters:
- ADDRW, 16, slave address width
- XLEN, 32, slave data width
- CLK_DIVIDER, 4, value written to reg 0x4 at configuration
- CTRL_INIT, 8'h01, value written to reg 0x0 byte 0 (bit0 enable, bit1 loopback, bit2 parity_en, bit3 parity odd, bit4 two stop)
- POLL_GAP, 0, idle cycles between consecutive status reads when no work is pending (16-bit counter)

Ports:
- aclk  in  1  clock
- aresetn  in  1  async active-low reset
- srst  in  1  sync active-high reset, same effect as aresetn
- slv_en  out  1  request valid
- slv_wr  out  1  1=write, 0=read
- slv_addr  out  ADDRW  register address
- slv_wdata  out  XLEN  write data
- slv_strb  out  XLEN/8  byte strobes
- slv_rdata  in  XLEN  read data
- slv_ready  in  1  request completion, one-cycle pulse
- s_valid  in  1  TX byte valid
- s_data  in  8  TX byte
- s_ready  out  1  one-cycle pulse, TX byte consumed
- m_valid  out  1  RX byte valid
- m_data  out  8  RX byte
- m_ready  in  1  RX byte accepted
- cfg_done  out  1  UART configured; stays high until reset

Behaviour:
- Reset (aresetn or srst):
  - slv_en, slv_wr, s_ready, m_valid, cfg_done = 0.
  - slv_addr, slv_wdata, slv_strb, m_data = 0.
  - FSM = CFG_DIV; poll counter = 0; rr flag = 0 (TX served last).
- Bus rule:
  - slv_en, slv_wr, slv_addr, slv_wdata and slv_strb are registered and held stable while slv_en=1 until slv_ready is sampled 1.
  - slv_en drops on the edge that samples slv_ready=1.
  - At least one cycle with slv_en=0 between requests.
  - slv_ready while slv_en=0 is ignored.
- FSM states:
  - CFG_DIV: write 0x4, wdata = CLK_DIVIDER[15:0], strb 4'b0011 -> CFG_CTRL on ready.
  - CFG_CTRL: write 0x0, wdata = CTRL_INIT, strb 4'b0001 -> STATUS on ready. cfg_done goes to 1 on the same edge.
  - STATUS: read 0x0, strb 0. On ready, latch tx_full = rdata[10] and rx_empty = rdata[11], then go to DECIDE.
  - DECIDE (no bus activity, one cycle):
    - rx_ok = !rx_empty && !m_valid.
    - tx_ok = s_valid && !tx_full.
    - Both ok: serve the one not served last (rr flag), then toggle rr.
    - One ok: serve it.
    - Neither ok: go to WAIT.
  - TX_WR: write 0x8, wdata = {24'b0, s_data}, strb 4'b0001. On ready, s_ready pulses 1 cycle, then -> STATUS.
  - RX_RD: read 0xC. On ready, m_data = rdata[7:0] and m_valid = 1, then -> STATUS.
  - WAIT: count POLL_GAP cycles, then -> STATUS. POLL_GAP=0 means go straight to STATUS.
- Status freshness: the status snapshot stays safe to act on because this block is the sole master.
  - tx_full can only fall.
  - rx_empty can only fall.
- Output stream:
  - m_valid clears on m_valid && m_ready.
  - m_data holds stable while m_valid=1.
  - Only one RX byte is buffered; RX reads are suppressed while m_valid=1.
- Input stream: s_data must hold stable while s_valid=1 until the s_ready pulse.
- Unmapped-address response (rdata all ones) cannot occur, since only 0x0/0x4/0x8/0xC are issued.
- Reset mid-transfer: slv_en drops immediately (asynchronously on aresetn); the full configuration sequence is rerun.

Optional Feature:
- Macro FRISCV_UART_CONSOLE_CRLF_EN.
- Defined: when s_data == 8'h0A, TX_WR first writes 8'h0D without pulsing s_ready, sets cr_sent, and returns to STATUS. The next TX service writes 8'h0A, then pulses s_ready and clears cr_sent. cr_sent resets to 0.
- Undefined: bytes are forwarded unmodified; no cr_sent flag exists.

Decomposition:
- Shared package friscv_h:
  - register address constants UART_CTRL=0x0, UART_DIV=0x4, UART_TX=0x8, UART_RX=0xC
  - status bit index constants TXFULL_BIT=10, RXEMPTY_BIT=11
  - console FSM enum
- One sub-module, friscv_uart_console_rxbuf: the 1-entry m_valid/m_data holding register with its handshake.
- The FSM stays in the top module.

Test Plan:
- Config after reset: release aresetn, model the slave with ready 2 cycles after en -> write 0x4 data 0x0004 strb 0x3, then write 0x0 data 0x01 strb 0x1, cfg_done=1, then first read of 0x0.
- TX path: status returns 0x0000_0A00, s_valid=1 with s_data=0x41 -> write 0x8 wdata=0x41, single s_ready pulse, s_valid low afterwards -> back to status polling only.
- TX full: status bit10=1 with s_valid=1 -> no 0x8 write; bus shows only 0x0 reads until bit10=0, then exactly one write.
- RX path and backpressure:
  - Setup: status bit11=0, rdata on 0xC = 0x5A, hold m_ready=0.
  - Expect: m_valid=1 with m_data=0x5A, and no further 0xC reads while m_valid=1.
  - Then: m_ready=1 for one cycle -> m_valid=0, next 0xC read issued.
- Fairness: rx_ok and tx_ok both true for 4 decisions -> access order alternates RX, TX, RX, TX with no consecutive repeats.
- CRLF_EN (macro defined): s_data=0x0A -> writes 0x0D then 0x0A, one s_ready pulse after the second write. Pulsing srst during the 0x0D write -> slv_en=0 next cycle and the CFG_DIV write is reissued.
